invaders_game_sequencer: RTL and testbench
==========================================

Name: invaders_game_sequencer

Overview:
Top-level game-flow controller for the invaders playfield. Sequences one game: attract/idle, play, inter-wave and life-lost pauses, game over. Drives the invaders formation's synchronous reset and the player/bullet enable. Keeps score, lives and level from the formation's hit, array and row outputs plus the player-hit pulse from the bomb logic.

Parameters:
LIVES, 3, lives at game start (1..3)
ROW_LIMIT, 14, formation row at or above which the game ends by invasion
SCORE_PER_HIT, 10, points added per invader hit
PAUSE_CYCLES, 25000000, pause length in clock cycles (1 s at 25 MHz)
MAX_LEVEL, 7, level saturation value

Ports:
i_clk_25MHz  in  1  system clock, 25 MHz
i_reset  in  1  asynchronous, active-high reset
i_start  in  1  start button, debounced level
i_hit  in  1  hit flag from the formation
i_invaders_array  in  20  live-invader bitmap from the formation
i_invaders_row  in  4  formation row from the formation
i_player_hit  in  1  single-cycle pulse: bomb struck player
o_invaders_reset  out  1  drives the formation's i_reset
o_enable  out  1  enables player movement, firing and bombs
o_state  out  2  0 IDLE, 1 PLAY, 2 PAUSE, 3 OVER
o_score  out  16  binary score
o_lives  out  2  remaining lives
o_level  out  3  current wave level, drives the speed select
o_game_over  out  1  high in OVER

Behaviour:
- Reset is one clock with an asynchronous, active-high reset (i_clk_25MHz, i_reset). All outputs are registered.
- Reset values: state IDLE, o_invaders_reset 1, o_enable 0, o_score 0, o_lives 0, o_level 0, o_game_over 0, pause counter 0, start-edge register 1. The start-edge register resets to 1 so a button held through reset does not start a game.
- Start edge: i_start is 1 now and was 0 on the previous clock.
- IDLE: o_invaders_reset=1, o_enable=0.
  - On a start edge: go to PLAY next cycle. Load score=0, lives=LIVES, level=0.
- PLAY: o_invaders_reset=0, o_enable=1.
- Hit counting: a rising edge of i_hit adds SCORE_PER_HIT to the score. The score saturates at 0xFFFF. Hits are counted in PLAY only.
- PLAY exit checks, evaluated each cycle in priority order:
  1. Invasion: i_invaders_row >= ROW_LIMIT. Go to OVER.
  2. Player hit: i_player_hit=1. Decrement lives.
     - If lives was 1: go to OVER with lives=0.
     - Otherwise: go to PAUSE with cause=LIFE.
  3. Wave clear: i_invaders_array == 0. Go to PAUSE with cause=WAVE.
- A score increment that coincides with a transition is still applied.
- PAUSE: o_enable=0. o_invaders_reset=1 if cause=WAVE, else 0. With cause=LIFE the formation is frozen only through o_enable gating of the player and bombs; its own tick keeps running.
  - The counter runs from 0 to PAUSE_CYCLES-1.
  - At terminal count: clear the counter, return to PLAY. If cause=WAVE, increment level, saturating at MAX_LEVEL.
  - PAUSE lasts exactly PAUSE_CYCLES cycles.
  - i_hit, i_player_hit and i_start are ignored in PAUSE.
- OVER: o_game_over=1, o_enable=0, o_invaders_reset=0 (the final formation stays displayed). Score, lives and level are held.
  - On a start edge: go to IDLE. o_invaders_reset rises the next cycle.
  - A further start edge is required to play.
- Asynchronous reset mid-game (any state): immediate return to reset values. No partial pause completes.
- o_state encoding as in Ports. Exactly one state at a time. No illegal encodings; all 2-bit codes are defined.

Optional Feature:
HIGH_SCORE_EN:
- Defined: adds output o_high_score (16). Reset value 0.
  - On the cycle the FSM enters OVER, if o_score > o_high_score, load o_score.
  - Only i_reset clears it; returning to IDLE does not.
- Undefined: the port and register are absent. All other behaviour is identical.

Test Plan:
1. Reset with i_start held high, then release and press -> stays IDLE until the press. Next cycle: PLAY, o_lives=3, o_score=0, o_invaders_reset=0, o_enable=1.
2. In PLAY, three separated i_hit pulses plus one i_hit held high for 5 cycles -> o_score=40. With o_score preset near 0xFFFA, further hits -> o_score saturates at 0xFFFF.
3. i_invaders_array driven to 0 in PLAY (PAUSE_CYCLES=16 in bench) -> PAUSE for 16 cycles with o_invaders_reset=1, then PLAY with o_level=1. Repeat 8 waves -> o_level stays 7.
4. Three i_player_hit pulses, each in PLAY -> lives 2 and 1 each followed by a 16-cycle PAUSE with o_invaders_reset=0; the third hit goes directly to OVER with o_lives=0, o_game_over=1.
5. i_invaders_row=14 and i_player_hit on the same cycle -> OVER, o_lives unchanged (invasion has priority). A start edge -> IDLE; a second start edge -> PLAY.
6. Assert i_reset mid-PAUSE -> outputs take reset values immediately, without waiting for a clock edge. With HIGH_SCORE_EN, games scoring 30 then 20 -> o_high_score=30.

Source files
------------

// File: rtl/invaders_game_sequencer.sv
// Game-flow controller for the invaders playfield: idle, play, pause and game-over sequencing with score/lives/level.
// Optional HIGH_SCORE_EN adds a high-score register that survives game restarts and is cleared only by i_reset.
module invaders_game_sequencer #(
    parameter int LIVES         = 3,
    parameter int ROW_LIMIT     = 14,
    parameter int SCORE_PER_HIT = 10,
    parameter int PAUSE_CYCLES  = 25000000,
    parameter int MAX_LEVEL     = 7
) (
    input  logic        i_clk_25MHz,
    input  logic        i_reset,
    input  logic        i_start,
    input  logic        i_hit,
    input  logic [19:0] i_invaders_array,
    input  logic [3:0]  i_invaders_row,
    input  logic        i_player_hit,
    output logic        o_invaders_reset,
    output logic        o_enable,
    output logic [1:0]  o_state,
    output logic [15:0] o_score,
    output logic [1:0]  o_lives,
    output logic [2:0]  o_level,
    output logic        o_game_over
`ifdef HIGH_SCORE_EN
    ,
    output logic [15:0] o_high_score
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PLAY  = 2'd1,
        PAUSE = 2'd2,
        OVER  = 2'd3
    } state_t;

    localparam int                CNT_W    = (PAUSE_CYCLES > 1) ? $clog2(PAUSE_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(PAUSE_CYCLES - 1);

    state_t           state;
    logic [CNT_W-1:0] pause_cnt;
    logic             start_prev;
    logic             hit_prev;
    logic             cause_wave;

    logic             start_edge;
    logic             hit_edge;
    logic             invasion;
    logic             go_over;
    logic [16:0]      score_sum;
    logic [15:0]      score_next;

    assign o_state    = state;
    assign start_edge = i_start & ~start_prev;
    assign hit_edge   = i_hit & ~hit_prev;
    assign invasion   = (i_invaders_row >= 4'(ROW_LIMIT));
    assign go_over    = (state == PLAY) && (invasion || (i_player_hit && o_lives == 2'd1));

    // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        score_sum  = {1'b0, o_score} + 17'(SCORE_PER_HIT);
        score_next = o_score;
        if (state == PLAY && hit_edge) begin
            score_next = score_sum[16] ? 16'hFFFF : score_sum[15:0];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge i_clk_25MHz or posedge i_reset) begin
        if (i_reset) begin
            state            <= IDLE;
            o_invaders_reset <= 1'b1;
            o_enable         <= 1'b0;
            o_score          <= 16'd0;
            o_lives          <= 2'd0;
            o_level          <= 3'd0;
            o_game_over      <= 1'b0;
            pause_cnt        <= '0;
            start_prev       <= 1'b1;  // a button held through reset must not start a game
            hit_prev         <= 1'b0;
            cause_wave       <= 1'b0;
        end else begin
            start_prev <= i_start;
            hit_prev   <= i_hit;
            case (state)
                IDLE: begin
                    if (start_edge) begin
                        state            <= PLAY;
                        o_score          <= 16'd0;
                        o_lives          <= 2'(LIVES);
                        o_level          <= 3'd0;
                        o_invaders_reset <= 1'b0;
                        o_enable         <= 1'b1;
                    end
                end
                PLAY: begin
                    o_score <= score_next;
                    if (invasion) begin
                        state       <= OVER;
                        o_enable    <= 1'b0;
                        o_game_over <= 1'b1;
                    end else if (i_player_hit) begin
                        o_lives  <= o_lives - 2'd1;
                        o_enable <= 1'b0;
                        if (o_lives == 2'd1) begin
                            state       <= OVER;
                            o_game_over <= 1'b1;
                        end else begin
                            state      <= PAUSE;
                            cause_wave <= 1'b0;
                            pause_cnt  <= '0;
                        end
                    end else if (i_invaders_array == 20'd0) begin
                        state            <= PAUSE;
                        cause_wave       <= 1'b1;
                        pause_cnt        <= '0;
                        o_enable         <= 1'b0;
                        o_invaders_reset <= 1'b1;
                    end
                end
                PAUSE: begin
                    if (pause_cnt == CNT_LAST) begin
                        pause_cnt        <= '0;
                        state            <= PLAY;
                        o_enable         <= 1'b1;
                        o_invaders_reset <= 1'b0;
                        if (cause_wave && o_level < 3'(MAX_LEVEL)) begin
                            o_level <= o_level + 3'd1;
                        end
                    end else begin
                        pause_cnt <= pause_cnt + 1'b1;
                    end
                end
                OVER: begin
                    if (start_edge) begin
                        state            <= IDLE;
                        o_game_over      <= 1'b0;
                        o_invaders_reset <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef HIGH_SCORE_EN
    // Captures the final score (including a coincident last hit) as the game enters OVER.
    always_ff @(posedge i_clk_25MHz or posedge i_reset) begin
        if (i_reset) begin
            o_high_score <= 16'd0;
        end else if (go_over && score_next > o_high_score) begin
            o_high_score <= score_next;
        end
    end
`else
    logic unused_go_over;
    assign unused_go_over = go_over;
`endif

endmodule

// File: tb/tb_invaders_game_sequencer.sv
// Bench for invaders_game_sequencer: game-rule model compared every cycle plus directed literal checks.
// Build with HIGH_SCORE_EN defined to also cover the high-score register.
module tb_invaders_game_sequencer;

    localparam int P = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b1;
    logic        hit = 1'b0;
    logic [19:0] inv_array = 20'hFFFFF;
    logic [3:0]  inv_row = 4'd0;
    logic        player_hit = 1'b0;

    logic        inv_reset, enable, game_over;
    logic [1:0]  state, lives;
    logic [15:0] score;
    logic [2:0]  level;

    // Second instance with a large per-hit value to reach the score ceiling quickly.
    logic        s_start = 1'b0;
    logic        s_hit = 1'b0;
    logic        s_inv_reset, s_enable, s_game_over;
    logic [1:0]  s_state, s_lives;
    logic [15:0] s_score;
    logic [2:0]  s_level;

`ifdef HIGH_SCORE_EN
    logic [15:0] high_score, s_high_score;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 1'b0;

    invaders_game_sequencer #(.PAUSE_CYCLES(P)) dut (
        .i_clk_25MHz      (clk),
        .i_reset          (rst),
        .i_start          (start),
        .i_hit            (hit),
        .i_invaders_array (inv_array),
        .i_invaders_row   (inv_row),
        .i_player_hit     (player_hit),
        .o_invaders_reset (inv_reset),
        .o_enable         (enable),
        .o_state          (state),
        .o_score          (score),
        .o_lives          (lives),
        .o_level          (level),
        .o_game_over      (game_over)
`ifdef HIGH_SCORE_EN
        ,
        .o_high_score     (high_score)
`endif
    );

    invaders_game_sequencer #(.PAUSE_CYCLES(P), .SCORE_PER_HIT(32765)) sat_dut (
        .i_clk_25MHz      (clk),
        .i_reset          (rst),
        .i_start          (s_start),
        .i_hit            (s_hit),
        .i_invaders_array (20'hFFFFF),
        .i_invaders_row   (4'd0),
        .i_player_hit     (1'b0),
        .o_invaders_reset (s_inv_reset),
        .o_enable         (s_enable),
        .o_state          (s_state),
        .o_score          (s_score),
        .o_lives          (s_lives),
        .o_level          (s_level),
        .o_game_over      (s_game_over)
`ifdef HIGH_SCORE_EN
        ,
        .o_high_score     (s_high_score)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- game-rule model ----------------
    int m_state;        // 0 idle, 1 play, 2 pause, 3 over
    int m_score, m_lives, m_level, m_pause_left, m_high;
    bit m_wave, m_prev_start, m_prev_hit;

    task automatic model_reset();
        m_state = 0; m_score = 0; m_lives = 0; m_level = 0;
        m_pause_left = 0; m_high = 0; m_wave = 0;
        m_prev_start = 1; m_prev_hit = 0;
    endtask

    task automatic model_enter_over();
        m_state = 3;
        if (m_score > m_high) m_high = m_score;
    endtask

    task automatic model_step();
        bit start_e, hit_e;
        start_e = start && !m_prev_start;
        hit_e   = hit && !m_prev_hit;
        case (m_state)
            0: if (start_e) begin
                m_state = 1; m_score = 0; m_lives = 3; m_level = 0;
            end
            1: begin
                if (hit_e) m_score = (m_score + 10 > 65535) ? 65535 : m_score + 10;
                if (inv_row >= 14) model_enter_over();
                else if (player_hit) begin
                    m_lives = m_lives - 1;
                    if (m_lives == 0) model_enter_over();
                    else begin m_state = 2; m_wave = 0; m_pause_left = P; end
                end else if (inv_array == 0) begin
                    m_state = 2; m_wave = 1; m_pause_left = P;
                end
            end
            2: begin
                m_pause_left = m_pause_left - 1;
                if (m_pause_left == 0) begin
                    m_state = 1;
                    if (m_wave && m_level < 7) m_level = m_level + 1;
                end
            end
            default: if (start_e) m_state = 0;
        endcase
        m_prev_start = start;
        m_prev_hit   = hit;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) model_reset();
            else model_step();
        end
    end

    // Every-cycle comparison against the model, sampled on the falling edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("m_state", 32'(state), 32'(m_state));
            check("m_score", 32'(score), 32'(m_score));
            check("m_lives", 32'(lives), 32'(m_lives));
            check("m_level", 32'(level), 32'(m_level));
            check("m_enable", 32'(enable), 32'(m_state == 1));
            check("m_game_over", 32'(game_over), 32'(m_state == 3));
            check("m_inv_reset", 32'(inv_reset), 32'(m_state == 0 || (m_state == 2 && m_wave)));
`ifdef HIGH_SCORE_EN
            check("m_high_score", 32'(high_score), 32'(m_high));
`endif
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic pulse_hit();
        hit = 1'b1; cyc(1);
        hit = 1'b0; cyc(1);
    endtask

    task automatic press_start();
        start = 1'b1; cyc(1);
        start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1: reset with start held; no game until a fresh press
        cyc(1);
        cmp_en = 1'b1;
        cyc(2);
        rst = 1'b0;
        cyc(3);
        check("idle_held_start", 32'(state), 32'd0);
        check("idle_inv_reset", 32'(inv_reset), 32'd1);
        start = 1'b0; cyc(1);
        press_start();
        check("play_state", 32'(state), 32'd1);
        check("play_lives", 32'(lives), 32'd3);
        check("play_score", 32'(score), 32'd0);
        check("play_inv_reset", 32'(inv_reset), 32'd0);
        check("play_enable", 32'(enable), 32'd1);

        // 2: three pulses plus one held hit
        for (int i = 0; i < 3; i++) pulse_hit();
        hit = 1'b1; cyc(5);
        hit = 1'b0; cyc(1);
        check("score_40", 32'(score), 32'd40);

        // saturation on the second instance
        s_start = 1'b1; cyc(1);
        s_start = 1'b0;
        check("sat_state", 32'(s_state), 32'd1);
        check("sat_enable", 32'(s_enable), 32'd1);
        check("sat_lives", 32'(s_lives), 32'd3);
        check("sat_level", 32'(s_level), 32'd0);
        check("sat_over", 32'(s_game_over), 32'd0);
        check("sat_inv_reset", 32'(s_inv_reset), 32'd0);
        s_hit = 1'b1; cyc(1); s_hit = 1'b0; cyc(1);
        s_hit = 1'b1; cyc(1); s_hit = 1'b0; cyc(1);
        check("sat_near", 32'(s_score), 32'hFFFA);
        s_hit = 1'b1; cyc(1); s_hit = 1'b0; cyc(1);
        check("sat_ceiling", 32'(s_score), 32'hFFFF);
        s_hit = 1'b1; cyc(1); s_hit = 1'b0; cyc(1);
        check("sat_hold", 32'(s_score), 32'hFFFF);
`ifdef HIGH_SCORE_EN
        check("sat_high_score", 32'(s_high_score), 32'd0);
`endif

        // 3: wave clear, inputs ignored during the pause
        inv_array = 20'd0; cyc(1);
        check("wave_pause", 32'(state), 32'd2);
        check("wave_inv_reset", 32'(inv_reset), 32'd1);
        inv_array = 20'hFFFFF;
        hit = 1'b1; player_hit = 1'b1; start = 1'b1; cyc(1);
        hit = 1'b0; player_hit = 1'b0; start = 1'b0;
        cyc(P - 2);
        check("wave_pause_last", 32'(state), 32'd2);
        cyc(1);
        check("wave_back_play", 32'(state), 32'd1);
        check("wave_level_1", 32'(level), 32'd1);
        check("wave_score_kept", 32'(score), 32'd40);
        for (int w = 0; w < 7; w++) begin
            inv_array = 20'd0; cyc(1);
            inv_array = 20'hFFFFF; cyc(P);
        end
        check("level_saturated", 32'(level), 32'd7);

        // 4: life losses; last one coincides with a hit
        for (int l = 2; l >= 1; l--) begin
            player_hit = 1'b1; cyc(1);
            player_hit = 1'b0;
            check("life_pause", 32'(state), 32'd2);
            check("life_lives", 32'(lives), 32'(l));
            check("life_inv_reset", 32'(inv_reset), 32'd0);
            cyc(P);
            check("life_resume", 32'(state), 32'd1);
        end
        player_hit = 1'b1; hit = 1'b1; cyc(1);
        player_hit = 1'b0; hit = 1'b0;
        check("last_life_over", 32'(state), 32'd3);
        check("last_life_lives", 32'(lives), 32'd0);
        check("last_life_flag", 32'(game_over), 32'd1);
        check("last_life_score", 32'(score), 32'd50);
        check("over_inv_reset", 32'(inv_reset), 32'd0);
        cyc(3);
        check("over_level_held", 32'(level), 32'd7);

        // 5: OVER -> IDLE -> PLAY, then invasion beats player hit
        press_start();
        check("over_to_idle", 32'(state), 32'd0);
        check("idle_inv_reset_again", 32'(inv_reset), 32'd1);
        cyc(1);
        press_start();
        check("replay", 32'(state), 32'd1);
        inv_row = 4'd13; cyc(1);
        check("row_13_play", 32'(state), 32'd1);
        inv_row = 4'd14; player_hit = 1'b1; cyc(1);
        inv_row = 4'd0; player_hit = 1'b0;
        check("invasion_over", 32'(state), 32'd3);
        check("invasion_lives", 32'(lives), 32'd3);
        press_start(); cyc(1);
        check("invasion_idle", 32'(state), 32'd0);
        press_start();
        check("invasion_replay", 32'(state), 32'd1);

        // 6: asynchronous reset mid-pause
        inv_array = 20'd0; cyc(1);
        inv_array = 20'hFFFFF; cyc(5);
        check("pre_reset_pause", 32'(state), 32'd2);
        #1 rst = 1'b1;
        #1;
        check("async_state", 32'(state), 32'd0);
        check("async_inv_reset", 32'(inv_reset), 32'd1);
        check("async_enable", 32'(enable), 32'd0);
        check("async_lives", 32'(lives), 32'd0);
        check("async_level", 32'(level), 32'd0);
        cyc(2);
        rst = 1'b0; cyc(1);

        // two games scoring 30 then 20
        press_start();
        for (int i = 0; i < 3; i++) pulse_hit();
        inv_row = 4'd14; cyc(1); inv_row = 4'd0;
        check("game1_score", 32'(score), 32'd30);
        press_start(); cyc(1);
        press_start();
        for (int i = 0; i < 2; i++) pulse_hit();
        inv_row = 4'd14; cyc(1); inv_row = 4'd0;
        check("game2_score", 32'(score), 32'd20);
`ifdef HIGH_SCORE_EN
        check("high_score_30", 32'(high_score), 32'd30);
`endif
        cyc(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
